// File: rtl/stack_controller.sv
// stack_controller
//   Multicycle Moore controller for the 8-bit stack-machine datapath. Walks
//   FETCH -> DECODE -> per-opcode states and issues the control strobes for
//   PC, IR, MDR, memory, stack, A/B registers and ALU.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   opcode        : IR[7:5] from the datapath (valid from DECODE onwards)
//   tos           : current top-of-stack value (JZ condition)
//   addrSrc       : memory address select, 0 = PC, 1 = IR[4:0]
//   mem_read      : memory read strobe
//   mem_write     : memory write strobe (data is stack top)
//   ir_write      : load IR
//   mdr_en        : load MDR
//   pc_write      : load PC
//   pc_src        : PC mux select, 0 = PC+incr, 1 = IR[4:0]
//   load_a/load_b : load A/B from stack top
//   push/pop      : stack push / pop
//   stack_src     : stack input select, 0 = ALU, 1 = MDR
//   alu_control   : 00 ADD, 01 SUB, 10 AND, 11 NOT(A)
//   instr_done    : one-cycle pulse in the last state of each instruction
//
// Handshake: none. Every strobe is a level that is valid for exactly the
// cycle in which the controller sits in the corresponding state.
module stack_controller #(
    parameter int OPCODE_W = 3,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   tos,
    output logic                addrSrc,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mdr_en,
    output logic                pc_write,
    output logic                pc_src,
    output logic                load_a,
    output logic                load_b,
    output logic                push,
    output logic                pop,
    output logic                stack_src,
    output logic [1:0]          alu_control,
    output logic                instr_done
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_POP_B    = 4'd3,
        S_POP_A    = 4'd4,
        S_EXEC     = 4'd5,
        S_MEM_RD   = 4'd6,
        S_PUSH_MDR = 4'd7,
        S_MEM_WR   = 4'd8,
        S_JUMP     = 4'd9,
        S_JZ       = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic       addr_src_q, addr_src_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       ir_write_q, ir_write_d;
    logic       mdr_en_q, mdr_en_d;
    logic       pc_write_q, pc_write_d;
    logic       pc_src_q, pc_src_d;
    logic       load_a_q, load_a_d;
    logic       load_b_q, load_b_d;
    logic       push_q, push_d;
    logic       pop_q, pop_d;
    logic       stack_src_q, stack_src_d;
    logic [1:0] alu_control_q, alu_control_d;
    logic       instr_done_q, instr_done_d;

    // Next-state logic.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode[2:0])
                    3'b000, 3'b001, 3'b010: state_d = S_POP_B;
                    3'b011:                 state_d = S_POP_A;
                    3'b100:                 state_d = S_MEM_RD;
                    3'b101:                 state_d = S_MEM_WR;
                    3'b110:                 state_d = S_JUMP;
                    default:                state_d = S_JZ;
                endcase
            end
            S_POP_B:    state_d = S_POP_A;
            S_POP_A:    state_d = S_EXEC;
            S_MEM_RD:   state_d = S_PUSH_MDR;
            S_EXEC,
            S_PUSH_MDR,
            S_MEM_WR,
            S_JUMP,
            S_JZ:       state_d = S_FETCH;
            default:    state_d = S_IDLE;   // unused encodings recover
        endcase
    end

    // Output registers hold the decode of the state being entered, so every
    // strobe is a clean flop output that is valid for the whole state.
    // The JZ condition is taken from tos at the end of DECODE; nothing touches
    // the stack in FETCH/DECODE/JZ, so that equals tos during JZ.
    always_comb begin
        addr_src_d    = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        ir_write_d    = 1'b0;
        mdr_en_d      = 1'b0;
        pc_write_d    = 1'b0;
        pc_src_d      = 1'b0;
        load_a_d      = 1'b0;
        load_b_d      = 1'b0;
        push_d        = 1'b0;
        pop_d         = 1'b0;
        stack_src_d   = 1'b0;
        alu_control_d = 2'b00;
        instr_done_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_read_d = 1'b1;
                ir_write_d = 1'b1;
                pc_write_d = 1'b1;
            end
            S_POP_B: begin
                load_b_d = 1'b1;
                pop_d    = 1'b1;
            end
            S_POP_A: begin
                load_a_d = 1'b1;
                pop_d    = 1'b1;
            end
            S_EXEC: begin
                push_d        = 1'b1;
                alu_control_d = opcode[1:0];
                instr_done_d  = 1'b1;
            end
            S_MEM_RD: begin
                addr_src_d = 1'b1;
                mem_read_d = 1'b1;
                mdr_en_d   = 1'b1;
            end
            S_PUSH_MDR: begin
                push_d       = 1'b1;
                stack_src_d  = 1'b1;
                instr_done_d = 1'b1;
            end
            S_MEM_WR: begin
                addr_src_d   = 1'b1;
                mem_write_d  = 1'b1;
                pop_d        = 1'b1;
                instr_done_d = 1'b1;
            end
            S_JUMP: begin
                pc_write_d   = 1'b1;
                pc_src_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            S_JZ: begin
                pc_write_d   = (tos == '0);
                pc_src_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_src_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            ir_write_q    <= 1'b0;
            mdr_en_q      <= 1'b0;
            pc_write_q    <= 1'b0;
            pc_src_q      <= 1'b0;
            load_a_q      <= 1'b0;
            load_b_q      <= 1'b0;
            push_q        <= 1'b0;
            pop_q         <= 1'b0;
            stack_src_q   <= 1'b0;
            alu_control_q <= 2'b00;
            instr_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_src_q    <= addr_src_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            ir_write_q    <= ir_write_d;
            mdr_en_q      <= mdr_en_d;
            pc_write_q    <= pc_write_d;
            pc_src_q      <= pc_src_d;
            load_a_q      <= load_a_d;
            load_b_q      <= load_b_d;
            push_q        <= push_d;
            pop_q         <= pop_d;
            stack_src_q   <= stack_src_d;
            alu_control_q <= alu_control_d;
            instr_done_q  <= instr_done_d;
        end
    end

    assign addrSrc     = addr_src_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign ir_write    = ir_write_q;
    assign mdr_en      = mdr_en_q;
    assign pc_write    = pc_write_q;
    assign pc_src      = pc_src_q;
    assign load_a      = load_a_q;
    assign load_b      = load_b_q;
    assign push        = push_q;
    assign pop         = pop_q;
    assign stack_src   = stack_src_q;
    assign alu_control = alu_control_q;
    assign instr_done  = instr_done_q;

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic [7:0] tos = 8'h00;

    logic       addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write, pc_src;
    logic       load_a, load_b, push, pop, stack_src, instr_done;
    logic [1:0] alu_control;

    always #5 clk = ~clk;

    stack_controller #(.OPCODE_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .tos(tos),
        .addrSrc(addrSrc), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mdr_en(mdr_en), .pc_write(pc_write),
        .pc_src(pc_src), .load_a(load_a), .load_b(load_b), .push(push),
        .pop(pop), .stack_src(stack_src), .alu_control(alu_control),
        .instr_done(instr_done)
    );

    // Packed view of all outputs:
    // [14]addrSrc [13]mem_read [12]mem_write [11]ir_write [10]mdr_en
    // [9]pc_write [8]pc_src [7]load_a [6]load_b [5]push [4]pop
    // [3]stack_src [2:1]alu_control [0]instr_done
    logic [14:0] outw;
    assign outw = {addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write,
                   pc_src, load_a, load_b, push, pop, stack_src, alu_control,
                   instr_done};

    localparam logic [14:0] B_ADDR  = 15'h4000;
    localparam logic [14:0] B_RD    = 15'h2000;
    localparam logic [14:0] B_WR    = 15'h1000;
    localparam logic [14:0] B_IRW   = 15'h0800;
    localparam logic [14:0] B_MDR   = 15'h0400;
    localparam logic [14:0] B_PCW   = 15'h0200;
    localparam logic [14:0] B_PCSRC = 15'h0100;
    localparam logic [14:0] B_LDA   = 15'h0080;
    localparam logic [14:0] B_LDB   = 15'h0040;
    localparam logic [14:0] B_PUSH  = 15'h0020;
    localparam logic [14:0] B_POP   = 15'h0010;
    localparam logic [14:0] B_SSRC  = 15'h0008;
    localparam logic [14:0] B_DONE  = 15'h0001;

    localparam logic [14:0] W_NONE  = 15'h0000;
    localparam logic [14:0] W_FETCH = B_RD | B_IRW | B_PCW;
    localparam logic [14:0] W_POPB  = B_LDB | B_POP;
    localparam logic [14:0] W_POPA  = B_LDA | B_POP;
    localparam logic [14:0] W_EXEC  = B_PUSH | B_DONE;   // alu bits OR'd in
    localparam logic [14:0] W_MRD   = B_ADDR | B_RD | B_MDR;
    localparam logic [14:0] W_PMDR  = B_PUSH | B_SSRC | B_DONE;
    localparam logic [14:0] W_MWR   = B_ADDR | B_WR | B_POP | B_DONE;
    localparam logic [14:0] W_JMP   = B_PCW | B_PCSRC | B_DONE;
    localparam logic [14:0] W_JZN   = B_PCSRC | B_DONE;

    // ---------------- scoreboard ----------------
    int          tests = 0;
    int          fails = 0;
    logic [14:0] exp_q[$];
    int          done_seen;

    task automatic check_word(input string name, input logic [14:0] exp);
        tests++;
        if (outw !== exp) begin
            fails++;
            $display("FAIL %s: outputs=%04h expected=%04h (t=%0t)", name, outw, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: micro-op sequence of one instruction, from FETCH to its
    // last state, built from the opcode's class.
    task automatic model_push(input logic [2:0] op, input logic [7:0] t);
        exp_q.push_back(W_FETCH);
        exp_q.push_back(W_NONE);
        if (op <= 3'd3) begin
            if (op != 3'd3) exp_q.push_back(W_POPB);   // binary ops pop B first
            exp_q.push_back(W_POPA);
            exp_q.push_back(W_EXEC | {12'd0, op[1:0], 1'b0});
        end else if (op == 3'd4) begin
            exp_q.push_back(W_MRD);
            exp_q.push_back(W_PMDR);
        end else if (op == 3'd5) begin
            exp_q.push_back(W_MWR);
        end else if (op == 3'd6) begin
            exp_q.push_back(W_JMP);
        end else begin
            exp_q.push_back((t == 8'h00) ? W_JMP : W_JZN);
        end
    endtask

    // Per-cycle invariants.
    task automatic check_invariants();
        check_bit("inv_push_pop", push & pop, 1'b0);
        check_bit("inv_rd_wr", mem_read & mem_write, 1'b0);
        check_bit("inv_irw_fetch", ir_write & ~(outw == W_FETCH), 1'b0);
    endtask

    // Drains exp_q one cycle per entry; called at a negedge with DUT in FETCH.
    task automatic drain(input string name, input logic do_inv);
        while (exp_q.size() > 0) begin
            check_word(name, exp_q.pop_front());
            if (do_inv) check_invariants();
            if (instr_done) done_seen++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [7:0]  tos;
        int          len;
        logic [14:0] w [5];
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{op:3'b001, tos:8'h11, len:5, w:'{W_FETCH, W_NONE, W_POPB, W_POPA, B_PUSH | B_DONE | 15'h0002}};
        vecs[1] = '{op:3'b100, tos:8'h22, len:4, w:'{W_FETCH, W_NONE, W_MRD, W_PMDR, W_NONE}};
        vecs[2] = '{op:3'b101, tos:8'h33, len:3, w:'{W_FETCH, W_NONE, W_MWR, W_NONE, W_NONE}};
        vecs[3] = '{op:3'b111, tos:8'h00, len:3, w:'{W_FETCH, W_NONE, W_JMP, W_NONE, W_NONE}};
        vecs[4] = '{op:3'b111, tos:8'h01, len:3, w:'{W_FETCH, W_NONE, W_JZN, W_NONE, W_NONE}};
        vecs[5] = '{op:3'b011, tos:8'h44, len:4, w:'{W_FETCH, W_NONE, W_POPA, B_PUSH | B_DONE | 15'h0006, W_NONE}};
        vecs[6] = '{op:3'b000, tos:8'h55, len:5, w:'{W_FETCH, W_NONE, W_POPB, W_POPA, B_PUSH | B_DONE}};
        vecs[7] = '{op:3'b010, tos:8'h00, len:5, w:'{W_FETCH, W_NONE, W_POPB, W_POPA, B_PUSH | B_DONE | 15'h0004}};
        vecs[8] = '{op:3'b110, tos:8'h00, len:3, w:'{W_FETCH, W_NONE, W_JMP, W_NONE, W_NONE}};

        // Reset held: outputs all zero.
        repeat (2) @(negedge clk);
        check_word("reset_hold", W_NONE);
        rst = 1'b0;                       // release at negedge: IDLE cycle
        check_word("idle_after_reset", W_NONE);
        @(negedge clk);
        check_word("fetch_after_reset", W_FETCH);

        // Table-driven directed instructions (DUT is in FETCH here).
        for (int i = 0; i < 9; i++) begin
            opcode = vecs[i].op;
            tos    = vecs[i].tos;
            for (int c = 0; c < vecs[i].len; c++) begin
                check_word($sformatf("vec%0d_op%b_cyc%0d", i, vecs[i].op, c + 1), vecs[i].w[c]);
                @(negedge clk);
            end
        end

        // Async reset in the middle of POP_B.
        opcode = 3'b001;
        tos    = 8'h77;
        check_word("rstseq_fetch", W_FETCH);
        @(negedge clk);
        @(negedge clk);
        check_word("rstseq_pop_b", W_POPB);
        rst = 1'b1;
        #1;
        check_word("rstseq_async_zero", W_NONE);
        @(negedge clk);
        check_word("rstseq_held_zero", W_NONE);
        rst = 1'b0;
        check_word("rstseq_idle", W_NONE);
        @(negedge clk);

        // Random instruction stream against the model.
        done_seen = 0;
        for (int n = 0; n < 200; n++) begin
            opcode = 3'($urandom_range(0, 7));
            tos    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            model_push(opcode, tos);
            drain($sformatf("rand%0d_op%b", n, opcode), 1'b1);
        end
        tests++;
        if (done_seen != 200) begin
            fails++;
            $display("FAIL instr_done_count: got %0d expected 200", done_seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
